keypad_entry: RTL
=================

# keypad_entry

Scans a 4x4 matrix keypad, debounces presses, and assembles two 16-bit hex operands for the FP MAC datapath. It sits directly upstream of the FP MAC control/datapath block. It drives that block's `IO_1`, `IO_2` and `current_state` inputs: operand A entry, then operand B entry, then compute. The four hex digits of each operand are entered most-significant first.

## Interface
- `SCAN_DIV`, 25000: clock cycles each column is driven low. At 100 MHz this gives a 1 ms full scan.
- `DEBOUNCE_CNT`, 10: consecutive identical full-scan results needed to change the debounced key.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `row`  in  4  keypad rows, active-low, externally pulled up, asynchronous.
- `btn_clear`  in  1  synchronous level, already debounced; clears entry.
- `col`  out  4  keypad columns, active-low, exactly one low at a time.
- `IO_1`  out  16  operand A being/been entered.
- `IO_2`  out  16  operand B being/been entered.
- `current_state`  out  2  00 idle, 01 entering A, 10 entering B, 11 compute.
- `key_valid`  out  1  one-cycle pulse per debounced press.
- `key_code`  out  4  hex code of last press; valid with `key_valid`, held after.
- `digit_count`  out  2  digits already stored in the operand currently being entered.

## Operation
- Reset values:
  - `col`=4'b1110.
  - `IO_1`=`IO_2`=16'h0000.
  - `current_state`=2'b00.
  - `key_valid`=0, `key_code`=4'h0, `digit_count`=0.
  - Scan counter, synchronizer, stable counter and debounced state all cleared (debounced = none).
- Scanning:
  - The column index c cycles 0,1,2,3,0… and advances every `SCAN_DIV` cycles.
  - `col` = ~(1<<c).
  - `row` passes through a 2-flop synchronizer.
  - Rows are sampled on the last cycle of each column dwell.
  - After column 3 is sampled, the full-scan result is formed: one key code if exactly one switch is closed, NONE if none is closed, MULTI if two or more are closed.
- Key map by (row r, col c):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Debounce:
  - If the scan result equals the previous scan result, the stable counter increments, saturating at `DEBOUNCE_CNT`. Otherwise it reloads to 1.
  - MULTI never updates the debounced state.
  - When the counter reaches `DEBOUNCE_CNT` with result K or NONE, the debounced state becomes that result.
  - A press event occurs only on a debounced NONE→key transition. A key→key transition (no release in between) produces no event.
- Press event: `key_valid`=1 for one cycle and `key_code`=key. This happens in every state, including 11.
- Entry FSM, on a press event with `btn_clear`=0:
  - 00: `IO_1`←{12'h000,key}, `digit_count`←1, state→01.
  - 01: `IO_1`←{`IO_1`[11:0],key}. If `digit_count` was 3, then state→10 and `digit_count`←0; otherwise `digit_count`+1.
  - 10: the same shift into `IO_2`. The 4th digit moves state→11 and sets `digit_count`←0.
  - 11: digits are ignored; operands are held.
- `btn_clear`=1, any state:
  - Next edge: state→00, `IO_1`=`IO_2`=0, `digit_count`=0.
  - The scanner and debouncer keep running.
  - If a press event coincides with clear, clear wins and the digit is dropped; `key_valid` still pulses.
- `reset` mid-scan or mid-entry: all outputs return to their reset values on the next edge. A key still held after reset is reported as a fresh press once it has debounced.

## Timing
- Column dwell is `SCAN_DIV` cycles; a full scan is 4·`SCAN_DIV` cycles.
- Row-to-sample latency: 2 cycles for the synchronizer. A switch change settling less than 2 cycles before the sample point may be missed until the next scan.
- Press latency: `key_valid` rises 1 cycle after the scan-complete cycle on which the `DEBOUNCE_CNT`-th identical result is formed.
- `IO_1`/`IO_2`, `digit_count` and `current_state` update on the same edge as `key_valid` rises.
- `current_state` is registered (glitch-free) and changes at most once per press event.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_CNT`=3.

- Reset, no key: `col` cycles 1110,1101,1011,0111 with 4 cycles each; `key_valid` never pulses; all outputs stay at their reset values.
- Press r1c2 held clean: exactly one `key_valid` with `key_code`=6, 1 cycle after the 3rd identical scan. `IO_1`=16'h0006, state=01. Holding the key longer produces no further pulses.
- Bounce: toggle r0c3 every scan for 5 scans, then hold it: one event, `key_code`=A. Release and re-press: a second event.
- Full entry of keys 3,C,0,0 then 4,0,0,0: `IO_1`=16'h3C00, `IO_2`=16'h4000. State sequence 00→01 (1st key) →10 (4th key) →11 (8th key). A 9th press pulses `key_valid` but leaves the operands unchanged.
- Two keys r0c0 and r2c1 closed together: no event. Releasing r2c1 leaves r0c0 alone and yields event `key_code`=1.
- `btn_clear` asserted on the same cycle as the 2nd digit's event: state=00, `IO_1`=0, `digit_count`=0, `key_valid` pulses, and the digit is dropped. `reset` asserted while in 10 gives all reset values on the next edge.

Source files
------------

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner with debounce. Builds two 16-bit hex
// operands (A, then B) and hands them to the FP MAC block together with an
// entry-phase code.
//
//   state   | meaning
//   --------+-------------------------------------------
//   ST_IDLE | 00, nothing entered yet (or just cleared)
//   ST_OP_A | 01, shifting digits into IO_1
//   ST_OP_B | 10, shifting digits into IO_2
//   ST_CALC | 11, both operands complete, digits ignored
module keypad_entry #(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row,
  input  logic        btn_clear,
  output logic [3:0]  col,
  output logic [15:0] IO_1,
  output logic [15:0] IO_2,
  output logic [1:0]  current_state,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [1:0]  digit_count
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  // Scan result = {kind, code}; code is only meaningful for RES_KEY.
  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_KEY   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OP_A = 2'b01,
    ST_OP_B = 2'b10,
    ST_CALC = 2'b11
  } state_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b0000: key_map = 4'h1;
      4'b0001: key_map = 4'h2;
      4'b0010: key_map = 4'h3;
      4'b0011: key_map = 4'hA;
      4'b0100: key_map = 4'h4;
      4'b0101: key_map = 4'h5;
      4'b0110: key_map = 4'h6;
      4'b0111: key_map = 4'hB;
      4'b1000: key_map = 4'h7;
      4'b1001: key_map = 4'h8;
      4'b1010: key_map = 4'h9;
      4'b1011: key_map = 4'hC;
      4'b1100: key_map = 4'hE;
      4'b1101: key_map = 4'h0;
      4'b1110: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  logic [SW-1:0] scan_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1, row_s2;
  logic          sample, scan_done;
  logic [1:0]    acc_hits, col_hits, tot_hits;
  logic [3:0]    acc_code, col_code, tot_code;
  logic [2:0]    hit_sum;
  logic [5:0]    scan_res, prev_res, deb_res;
  logic [DW-1:0] stable_cnt, stable_next;
  logic          settle, press;
  state_t        state, state_next;
  logic [15:0]   io1_next, io2_next;
  logic [1:0]    dc_next;

  // Sample point is the terminal count of the dwell down-counter.
  assign sample    = (scan_cnt == '0);
  assign scan_done = sample && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);

  // Column dwell timer and column index.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt <= SW'(SCAN_DIV - 1);
      col_idx  <= 2'd0;
    end else if (sample) begin
      scan_cnt <= SW'(SCAN_DIV - 1);
      col_idx  <= col_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt - SW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous row lines; idle level is all-high.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Closed switches in the currently driven column (hit count saturates at 2).
  always_comb begin
    col_hits = 2'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        col_code = key_map(2'(r), col_idx);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  // Merge this column into the running scan totals and classify the full scan.
  always_comb begin
    hit_sum  = {1'b0, acc_hits} + {1'b0, col_hits};
    tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    tot_code = (col_hits != 2'd0) ? col_code : acc_code;
    case (tot_hits)
      2'd0:    scan_res = {RES_NONE, 4'h0};
      2'd1:    scan_res = {RES_KEY, tot_code};
      default: scan_res = {RES_MULTI, 4'h0};
    endcase
  end

  // Per-scan accumulator, restarted after column 3 is folded in.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      acc_hits <= (col_idx == 2'd3) ? 2'd0 : tot_hits;
      acc_code <= (col_idx == 2'd3) ? 4'h0 : tot_code;
    end
  end

  assign stable_next = (scan_res != prev_res)                ? DW'(1) :
                       (stable_cnt == DW'(DEBOUNCE_CNT))     ? stable_cnt :
                                                               stable_cnt + DW'(1);
  assign settle = (stable_next == DW'(DEBOUNCE_CNT)) && (scan_res[5:4] != RES_MULTI);
  // Only a release-to-key transition counts; key-to-key rollover is silent.
  assign press  = scan_done && settle && (deb_res[5:4] == RES_NONE) &&
                  (scan_res[5:4] == RES_KEY);

  // Debounce: run length of identical scans and the debounced key state.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_res   <= {RES_NONE, 4'h0};
      stable_cnt <= '0;
      deb_res    <= {RES_NONE, 4'h0};
    end else if (scan_done) begin
      prev_res   <= scan_res;
      stable_cnt <= stable_next;
      if (settle) deb_res <= scan_res;
    end
  end

  // Press event pulse and held key code, reported in every entry state.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_valid <= press;
      if (press) key_code <= scan_res[3:0];
    end
  end

  // Entry FSM state and operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      IO_1        <= 16'h0000;
      IO_2        <= 16'h0000;
      digit_count <= 2'd0;
    end else begin
      state       <= state_next;
      IO_1        <= io1_next;
      IO_2        <= io2_next;
      digit_count <= dc_next;
    end
  end

  // Entry FSM next state; clear overrides a coincident digit.
  always_comb begin
    state_next = state;
    io1_next   = IO_1;
    io2_next   = IO_2;
    dc_next    = digit_count;
    if (btn_clear) begin
      state_next = ST_IDLE;
      io1_next   = 16'h0000;
      io2_next   = 16'h0000;
      dc_next    = 2'd0;
    end else if (press) begin
      case (state)
        ST_IDLE: begin
          io1_next   = {12'h000, scan_res[3:0]};
          dc_next    = 2'd1;
          state_next = ST_OP_A;
        end
        ST_OP_A: begin
          io1_next = {IO_1[11:0], scan_res[3:0]};
          dc_next  = digit_count + 2'd1;
          if (digit_count == 2'd3) state_next = ST_OP_B;
        end
        ST_OP_B: begin
          io2_next = {IO_2[11:0], scan_res[3:0]};
          dc_next  = digit_count + 2'd1;
          if (digit_count == 2'd3) state_next = ST_CALC;
        end
        default: ;
      endcase
    end
  end

  assign current_state = state;
endmodule
